and_gate_rr_arbiter: RTL

- Shares one registered bitwise-AND datapath between NUM_REQ requesters, each supplying an operand pair over a valid/ready handshake.
- Round-robin arbitration selects one request per cycle. The block registers a & b and returns the result with the winner's ID on a single valid/ready response channel.
- Sits between the AND-gate input agents/stimulus sources and the AND-gate result consumer. It is the sequencing front end of the AND datapath.

---
 rtl/and_gate_rr_arbiter_pkg.sv | 36 +++
 rtl/and_gate_rr_arbiter_picker.sv | 38 +++
 rtl/and_gate_rr_arbiter.sv | 89 ++++++++
 3 files changed

// File: rtl/and_gate_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin AND-gate arbiter.
// rr_pick is a behavioural reference of the arbitration order.
package and_gate_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int MAX_REQ     = 16;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_e;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // Scan ptr, ptr+1, ... modulo n; the first valid index wins.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input int unsigned n,
                                    input int unsigned ptr);
    pick_t       p;
    int unsigned j;
    p = '0;
    for (int unsigned k = 0; k < n; k++) begin
      j = (ptr + k) % n;
      if (!p.found && valid[j[3:0]]) begin
        p.found = 1'b1;
        p.idx   = j[3:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/and_gate_rr_arbiter_picker.sv
// Combinational round-robin picker: first valid requester at or after
// rr_ptr (wrapping) wins; one-hot grant plus encoded index.
module and_gate_rr_picker
  import and_gate_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               found
);

  always_comb begin
    int              s;
    logic [ID_W-1:0] j;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a missing default on some path infers a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    s         = 0;
    j         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = int'(rr_ptr) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      j = ID_W'(s);
      if (!found && req_valid[j]) begin
        found     = 1'b1;
        grant_idx = j;
        grant[j]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/and_gate_rr_arbiter.sv
// Round-robin front end sharing one registered a & b datapath between
// NUM_REQ valid/ready requesters, with a single response channel.
module and_gate_rr_arbiter
  import and_gate_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  parameter  int DATA_W  = DEF_DATA_W,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_y,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy
);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]  rsp_y_q, rsp_y_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    win;
  logic               found;
  logic               can_accept;
  logic               req_fire;
  logic [DATA_W-1:0]  win_a, win_b;

  and_gate_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (win),
    .found     (found)
  );

  assign win_a = req_a[win*DATA_W +: DATA_W];
  assign win_b = req_b[win*DATA_W +: DATA_W];

  always_comb begin
    can_accept = (state_q == IDLE) || rsp_ready;
    // Gated by rst so no request is accepted while reset is asserted,
    // even though the registered state already reads as IDLE.
    req_ready  = (!rst && can_accept && found) ? grant : '0;
    req_fire   = |req_ready;

    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    rsp_y_d  = rsp_y_q;
    rsp_id_d = rsp_id_q;

    if (req_fire) begin
      state_d  = FULL;
      rsp_y_d  = win_a & win_b;
      rsp_id_d = win;
      rr_ptr_d = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end else if (state_q == FULL && rsp_ready) begin
      state_d = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      rsp_y_q  <= '0;
      rsp_id_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      rsp_y_q  <= rsp_y_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = rsp_valid | (|req_valid);

endmodule
